sequence_generator: RTL and testbench
=====================================

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits.
REQ-002 Parameter PATTERN, default 4'b0110, bit pattern transmitted MSB first.
REQ-003 Parameter CNT_W, default 4, width of the repetition count.
REQ-004 Parameter IDLE_BIT, default 1'b1, level driven on x when no pattern bit is sent.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-008 count  input  CNT_W  number of pattern repetitions; latched with start.
REQ-009 gap_en  input  1  insert one idle bit between repetitions; latched with start.
REQ-010 x  output  1  serial data bit, registered.
REQ-011 x_valid  output  1  high when x carries a pattern bit, registered.
REQ-012 busy  output  1  high in any state other than IDLE, registered.
REQ-013 done  output  1  one-cycle pulse at end of burst, registered.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, GAP, FINISH.
REQ-015 IDLE: start=1 SHALL latch count and gap_en and move to SEND, or to FINISH if count=0.
REQ-016 The first pattern bit SHALL appear on x with x_valid=1 in the cycle after start is sampled.
REQ-017 SEND SHALL output PATTERN[PAT_W-1-bit_idx], one bit per cycle, with bit_idx counting 0..PAT_W-1.
REQ-018 After bit PAT_W-1, the block SHALL decrement the remaining count and go to FINISH if the count reaches 0, to GAP if gap_en=1, and otherwise remain in SEND with bit_idx=0 (back-to-back).
REQ-019 GAP SHALL last exactly one cycle with x=IDLE_BIT and x_valid=0, then return to SEND with bit_idx=0.
REQ-020 FINISH SHALL last one cycle with done=1, x=IDLE_BIT, x_valid=0, then return to IDLE.
REQ-021 Total valid bits per burst SHALL equal count*PAT_W; burst length in cycles SHALL be count*PAT_W + (count-1)*gap_en + 1 (FINISH).
REQ-022 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-023 Changes to count or gap_en after latching SHALL NOT affect the current burst.
REQ-024 start may be asserted in the cycle after done is asserted (IDLE), so a new burst can follow with a one-cycle idle gap.
REQ-025 count=2^CNT_W-1 SHALL be supported without counter wrap.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, x=IDLE_BIT, x_valid=0, busy=0, done=0, and clear the counters.
REQ-027 Reset mid-burst SHALL abort the burst with no done pulse; operation resumes on the next start after rst deasserts.

Structure
REQ-028 Package seq_pkg SHALL hold the FSM state typedef and the default pattern constant 4'b0110, shared with the detector in the codebase.
REQ-029 The design SHALL be a single module; no sub-module is required, and the bit and repetition counters stay inline.

Verification
REQ-030 count=1, gap_en=0, start pulse -> x_valid high for 4 cycles, x=0,1,1,0, then done pulse, busy low.
REQ-031 count=3, gap_en=0, with output fed into the codebase's 0110 sequence detector -> detector z pulses 3 times, at cycles 4, 8 and 12 after start.
REQ-032 count=2, gap_en=1 -> x=0,1,1,0,1(gap, x_valid=0),0,1,1,0, then done; 10 busy cycles in total.
REQ-033 count=0 -> no x_valid, done high in cycle 1 after start, busy high for exactly 1 cycle.
REQ-034 start re-pulsed mid-burst -> ignored, bit count is unchanged; rst asserted at bit 2 -> x=1, x_valid=0 immediately, no done pulse.
REQ-035 count=15, gap_en=1 -> 60 valid bits and 14 gap cycles, single done pulse, no counter wrap.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: FSM state encoding and default pattern shared by the sequence generator and detector
package seq_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t SEND   = 2'd1;
  localparam state_t GAP    = 2'd2;
  localparam state_t FINISH = 2'd3;
  localparam logic [3:0] DEF_PATTERN = 4'b0110;
endpackage

// File: rtl/sequence_generator.sv
// sequence_generator: serialises a fixed bit pattern MSB first, repeated count times with optional idle gaps
module sequence_generator
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int CNT_W = 4,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             gap_en,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = PAT_W > 1 ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] ONE = 1;
  state_t state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic gap_q, gap_d;
  logic last, go;
  // Next state, bit index and remaining repetitions; count and gap_en are only sampled on an accepted start
  always_comb begin
    last = bit_q == LAST;
    go = state_q == IDLE && start;
    state_d = state_q == IDLE ? (start ? (count == '0 ? FINISH : SEND) : IDLE) :
              state_q == SEND ? (last ? (rem_q == ONE ? FINISH : gap_q ? GAP : SEND) : SEND) :
              state_q == GAP  ? SEND : IDLE;
    bit_d = (state_q == SEND && !last) ? bit_q + BW'(1) : '0;
    rem_d = go ? count : (state_q == SEND && last) ? rem_q - ONE : rem_q;
    gap_d = go ? gap_en : gap_q;
  end
  // State registers plus outputs registered from the next state so x lines up with the state it describes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      rem_q   <= '0;
      gap_q   <= 1'b0;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      x       <= state_d == SEND ? PATTERN[LAST - bit_d] : IDLE_BIT;
      x_valid <= state_d == SEND;
      busy    <= state_d != IDLE;
      done    <= state_d == FINISH;
    end
  end
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: randomized bursts checked against a per-cycle expected stream built from the pattern rules
module tb_sequence_generator;
  localparam logic [3:0] PAT = 4'b0110;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] count = '0;
  logic gap_en = 1'b0;
  logic x, x_valid, busy, done;
  int checks = 0;
  int errors = 0;
  int hits[$];

  sequence_generator dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .gap_en(gap_en),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge; start is raised immediately and the task returns at the negedge after done.
  task automatic burst(input int c, input bit g, input bit noise);
    logic [3:0] q[$];
    logic [3:0] got;
    logic [3:0] sh;
    int nv, nd, ng;
    for (int r = 0; r < c; r++) begin
      for (int b = 0; b < 4; b++) q.push_back({PAT[3-b], 1'b1, 1'b1, 1'b0});
      if (g && r < c - 1) q.push_back(4'b1010);
    end
    q.push_back(4'b1011);
    hits.delete();
    sh = '0; nv = 0; nd = 0; ng = 0;
    start = 1'b1; count = 4'(c); gap_en = g;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      got = {x, x_valid, busy, done};
      checks++;
      if (got !== q[i]) begin
        errors++;
        $display("FAIL burst c=%0d g=%0d cyc=%0d {x,v,busy,done} got %b exp %b", c, g, i + 1, got, q[i]);
      end
      if (x_valid) begin
        nv++;
        sh = {sh[2:0], x};
        if (nv >= 4 && sh == PAT) hits.push_back(i + 1);
      end
      nd += int'(done);
      if (busy && !x_valid && !done) ng++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        count = 4'($urandom);
        gap_en = 1'($urandom);
      end
    end
    start = 1'b0;
    checks++;
    if (nv !== c * 4) begin
      errors++;
      $display("FAIL valid_bits c=%0d got %0d exp %0d", c, nv, c * 4);
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL done_pulses c=%0d got %0d exp 1", c, nd);
    end
    checks++;
    if (ng !== ((c > 0 && g) ? c - 1 : 0)) begin
      errors++;
      $display("FAIL gap_cycles c=%0d got %0d exp %0d", c, ng, (c > 0 && g) ? c - 1 : 0);
    end
    @(negedge clk);
    checks++;
    if ({x, x_valid, busy, done} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after c=%0d got %b exp 1000", c, {x, x_valid, busy, done});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({x, x_valid, busy, done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset got %b exp 1000", {x, x_valid, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    burst(1, 0, 0);
  endtask

  task automatic test_detect();
    burst(3, 0, 0);
    checks++;
    if (hits.size() !== 3 || hits[0] !== 4 || hits[1] !== 8 || hits[2] !== 12) begin
      errors++;
      $display("FAIL detect hits got %0d at %p exp 3 at 4,8,12", hits.size(), hits);
    end
  endtask

  task automatic test_gap();
    burst(2, 1, 0);
  endtask

  task automatic test_zero();
    burst(0, 1, 0);
    burst(0, 0, 1);
  endtask

  task automatic test_ignore_start();
    burst(3, 0, 1);
    burst(4, 1, 1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; count = 4'd3; gap_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({x, x_valid} !== 2'b11) begin
      errors++;
      $display("FAIL mid_bit2 got %b exp 11", {x, x_valid});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({x, x_valid, busy, done} !== 4'b1000) begin
      errors++;
      $display("FAIL async_reset got %b exp 1000", {x, x_valid, busy, done});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d {busy,done} got %b exp 00", i, {busy, done});
      end
    end
    rst = 1'b0;
    burst(1, 0, 0);
  endtask

  task automatic test_max();
    burst(15, 1, 0);
    burst(15, 0, 1);
  endtask

  task automatic test_back_to_back();
    burst(2, 0, 0);
    burst(1, 1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) burst($urandom_range(0, 15), 1'($urandom), 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_detect();
    test_gap();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_max();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
